time_counter: RTL and testbench

TIME_COUNTER -- requirements
Module: time_counter

---
 rtl/clock_pkg.sv | 29 ++
 rtl/edge_sync.sv | 38 +++
 rtl/time_counter.sv | 92 +++++++++
 tb/tb_time_counter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared time-of-day constants and helpers for the counter, BCD converter,
// display and alarm blocks.
package clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } hms_t;

    // Hour increment with 23 -> 0 wrap.
    function automatic logic [HOUR_W-1:0] hour_inc(input logic [HOUR_W-1:0] h);
        return (h == HOUR_MAX) ? '0 : h + 5'd1;
    endfunction

    // Minute/second increment with 59 -> 0 wrap (both fields share width and max).
    function automatic logic [MIN_W-1:0] sixty_inc(input logic [MIN_W-1:0] v);
        return (v == MIN_MAX) ? '0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous button followed by a
// rising-edge detector. A level first sampled high at edge n gives a
// rise pulse during the cycle after edge n+1, so the consumer acts at n+2.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Next-state: shift the button through the synchronizer and remember the last level.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchronizer and edge-history flops; all cleared by reset so a held button
    // is seen as a fresh edge after release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/time_counter.sv
// 24-hour time-of-day counter with a one-second prescaler, set mode driven
// by two debounced-elsewhere buttons, and registered TICK / DAY_ROLL pulses.
module time_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 50000000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              RUN,
    input  logic              SET_HR,
    input  logic              SET_MIN,
    output logic [HOUR_W-1:0] HOUR,
    output logic [MIN_W-1:0]  MIN,
    output logic [SEC_W-1:0]  SEC,
    output logic              TICK,
    output logic              DAY_ROLL
);

    localparam int              PW         = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_q, presc_d;
    hms_t          time_q, time_d;
    logic          tick_q, tick_d;
    logic          day_roll_q, day_roll_d;
    logic          hr_rise, min_rise;

    edge_sync u_sync_hr (
        .clk      (CLK),
        .rst_n    (RST_N),
        .async_in (SET_HR),
        .rise     (hr_rise)
    );

    edge_sync u_sync_min (
        .clk      (CLK),
        .rst_n    (RST_N),
        .async_in (SET_MIN),
        .rise     (min_rise)
    );

    // Next-state: prescaler, second/minute/hour cascade in run mode, field
    // increments in set mode. Button edges seen while running are dropped.
    always_comb begin
        presc_d    = presc_q;
        time_d     = time_q;
        tick_d     = 1'b0;
        day_roll_d = 1'b0;
        if (RUN) begin
            tick_d  = (presc_q == PRESC_LAST);
            presc_d = tick_d ? '0 : presc_q + PW'(1);
            if (tick_d) begin
                time_d.sec = sixty_inc(time_q.sec);
                if (time_q.sec == SEC_MAX) begin
                    time_d.min = sixty_inc(time_q.min);
                    if (time_q.min == MIN_MAX) begin
                        time_d.hour = hour_inc(time_q.hour);
                        day_roll_d  = (time_q.hour == HOUR_MAX);
                    end
                end
            end
        end else begin
            presc_d    = '0;
            time_d.sec = '0;
            if (hr_rise)  time_d.hour = hour_inc(time_q.hour);
            if (min_rise) time_d.min  = sixty_inc(time_q.min);
        end
    end

    // State and output registers; reset wins over everything.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            presc_q    <= '0;
            time_q     <= '0;
            tick_q     <= 1'b0;
            day_roll_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            time_q     <= time_d;
            tick_q     <= tick_d;
            day_roll_q <= day_roll_d;
        end
    end

    assign HOUR     = time_q.hour;
    assign MIN      = time_q.min;
    assign SEC      = time_q.sec;
    assign TICK     = tick_q;
    assign DAY_ROLL = day_roll_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter at CLK_HZ=4: reset, tick cadence, minute
// and day rollover, set-mode buttons, run-mode edge discard, mid-count reset.
module tb_time_counter;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       RUN = 1'b0;
    logic       SET_HR = 1'b0;
    logic       SET_MIN = 1'b0;
    logic [4:0] HOUR;
    logic [5:0] MIN;
    logic [5:0] SEC;
    logic       TICK;
    logic       DAY_ROLL;

    int n_cmp = 0;
    int n_bad = 0;

    time_counter #(.CLK_HZ(4)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .RUN      (RUN),
        .SET_HR   (SET_HR),
        .SET_MIN  (SET_MIN),
        .HOUR     (HOUR),
        .MIN      (MIN),
        .SEC      (SEC),
        .TICK     (TICK),
        .DAY_ROLL (DAY_ROLL)
    );

    always #5 CLK = ~CLK;

    // One rising edge; inputs change and outputs are read 1 time unit after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        RST_N = 1'b0;
        repeat (cycles) step();
        RST_N = 1'b1;
    endtask

    task automatic pulse(input logic hr, input logic mn);
        SET_HR = hr; SET_MIN = mn;
        step();
        SET_HR = 1'b0; SET_MIN = 1'b0;
        step();
    endtask

    task automatic test_reset();
        RUN = 1'b1; SET_HR = 1'b1; SET_MIN = 1'b1;
        do_reset(2);
        n_cmp++;
        if ({HOUR, MIN, SEC, TICK, DAY_ROLL} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got h=%0d m=%0d s=%0d t=%b d=%b, want all 0",
                     HOUR, MIN, SEC, TICK, DAY_ROLL);
        end
        // Buttons held through release while running: edges must be discarded.
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (TICK !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_no_early_tick: cycle %0d got TICK=%b, want 0", i, TICK);
            end
        end
        step();
        n_cmp++;
        if (TICK !== 1'b1 || SEC !== 6'd1) begin
            n_bad++;
            $display("FAIL first_tick: got TICK=%b SEC=%0d, want TICK=1 SEC=1", TICK, SEC);
        end
        n_cmp++;
        if (HOUR !== 5'd0 || MIN !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_buttons_ignored: got h=%0d m=%0d, want 0/0", HOUR, MIN);
        end
        SET_HR = 1'b0; SET_MIN = 1'b0;
    endtask

    // Continues from test_reset: 4 edges already elapsed since release.
    task automatic test_minute_roll();
        int bad_pat = 0;
        for (int i = 4; i < 240; i++) begin
            step();
            if (TICK !== ((i % 4) == 3)) bad_pat++;
        end
        n_cmp++;
        if (bad_pat != 0) begin
            n_bad++;
            $display("FAIL tick_cadence: got %0d cycles with wrong TICK, want 0", bad_pat);
        end
        n_cmp++;
        if (MIN !== 6'd1 || SEC !== 6'd0 || HOUR !== 5'd0) begin
            n_bad++;
            $display("FAIL minute_roll: got h=%0d m=%0d s=%0d, want 0:1:0", HOUR, MIN, SEC);
        end
    endtask

    task automatic test_day_roll();
        int ticks = 0, rolls = 0, roll_at = -1;
        RUN = 1'b1;
        do_reset(1);
        RUN = 1'b0;
        // One simultaneous pulse, checked for exact latency: sampled at n, applied at n+2.
        SET_HR = 1'b1; SET_MIN = 1'b1;
        step();
        SET_HR = 1'b0; SET_MIN = 1'b0;
        step();
        n_cmp++;
        if (HOUR !== 5'd0 || MIN !== 6'd0) begin
            n_bad++;
            $display("FAIL both_latency_early: got h=%0d m=%0d at n+1, want 0/0", HOUR, MIN);
        end
        step();
        n_cmp++;
        if (HOUR !== 5'd1 || MIN !== 6'd1) begin
            n_bad++;
            $display("FAIL both_simultaneous: got h=%0d m=%0d at n+2, want 1/1", HOUR, MIN);
        end
        repeat (22) pulse(1'b1, 1'b1);
        repeat (36) pulse(1'b0, 1'b1);
        step(); step();
        n_cmp++;
        if (HOUR !== 5'd23 || MIN !== 6'd59 || SEC !== 6'd0 || DAY_ROLL !== 1'b0) begin
            n_bad++;
            $display("FAIL set_to_2359: got h=%0d m=%0d s=%0d d=%b, want 23:59:0 d=0",
                     HOUR, MIN, SEC, DAY_ROLL);
        end
        RUN = 1'b1;
        for (int i = 0; i < 240; i++) begin
            step();
            if (TICK === 1'b1) ticks++;
            if (DAY_ROLL === 1'b1) begin
                rolls++;
                if (TICK === 1'b1) roll_at = ticks;
            end
        end
        n_cmp++;
        if (rolls != 1 || roll_at != 60) begin
            n_bad++;
            $display("FAIL day_roll_pulse: got %0d pulses at tick %0d, want 1 at tick 60", rolls, roll_at);
        end
        n_cmp++;
        if (HOUR !== 5'd0 || MIN !== 6'd0 || SEC !== 6'd0) begin
            n_bad++;
            $display("FAIL day_roll_wrap: got h=%0d m=%0d s=%0d, want 0:0:0", HOUR, MIN, SEC);
        end
        RUN = 1'b0;
        step();
    endtask

    task automatic test_set_hold();
        logic [4:0] h0;
        logic [5:0] m0;
        RUN = 1'b0;
        pulse(1'b0, 1'b1); pulse(1'b0, 1'b1); step(); step();
        h0 = HOUR; m0 = MIN;
        SET_HR = 1'b1;
        step(); step();
        n_cmp++;
        if (HOUR !== h0) begin
            n_bad++;
            $display("FAIL hold_latency_early: got h=%0d at n+1, want %0d", HOUR, h0);
        end
        step();
        n_cmp++;
        if (HOUR !== h0 + 5'd1) begin
            n_bad++;
            $display("FAIL hold_latency: got h=%0d at n+2, want %0d", HOUR, h0 + 5'd1);
        end
        repeat (7) step();
        SET_HR = 1'b0;
        step(); step();
        n_cmp++;
        if (HOUR !== h0 + 5'd1) begin
            n_bad++;
            $display("FAIL hold_single_inc: got h=%0d, want %0d", HOUR, h0 + 5'd1);
        end
        repeat (23) pulse(1'b1, 1'b0);
        step(); step();
        n_cmp++;
        if (HOUR !== h0 || MIN !== m0) begin
            n_bad++;
            $display("FAIL hour_wrap_24: got h=%0d m=%0d, want %0d/%0d", HOUR, MIN, h0, m0);
        end
    endtask

    task automatic test_run_drop();
        logic [5:0] m0;
        m0 = MIN;
        RUN = 1'b1;
        repeat (9) step();
        n_cmp++;
        if (SEC !== 6'd2) begin
            n_bad++;
            $display("FAIL run_resume_sec: got s=%0d, want 2", SEC);
        end
        SET_MIN = 1'b1;
        repeat (3) step();
        RUN = 1'b0;
        repeat (5) step();
        n_cmp++;
        if (MIN !== m0 || SEC !== 6'd0 || TICK !== 1'b0) begin
            n_bad++;
            $display("FAIL run_drop_held: got m=%0d s=%0d t=%b, want m=%0d s=0 t=0", MIN, SEC, TICK, m0);
        end
        SET_MIN = 1'b0;
        step();
    endtask

    task automatic test_mid_reset();
        RUN = 1'b1;
        do_reset(1);
        repeat (150) step();
        n_cmp++;
        if (SEC !== 6'd37) begin
            n_bad++;
            $display("FAIL mid_count_sec: got s=%0d, want 37", SEC);
        end
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        n_cmp++;
        if ({HOUR, MIN, SEC, TICK, DAY_ROLL} !== 19'd0) begin
            n_bad++;
            $display("FAIL mid_count_reset: got h=%0d m=%0d s=%0d t=%b, want all 0", HOUR, MIN, SEC, TICK);
        end
        step(); step(); step();
        n_cmp++;
        if (TICK !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_presc: got TICK=%b 3 cycles after release, want 0", TICK);
        end
        RUN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_minute_roll();
        test_day_roll();
        test_set_hold();
        test_run_drop();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
